// File: rtl/stream_fifo_buf.sv
// Valid/ready stream buffer with DEPTH registered entries, occupancy outputs and synchronous flush; optional STREAM_FIFO_BUF_FALLTHROUGH_EN.
// Latency: 1 cycle from push to out_valid (0 cycles when empty with the fallthrough macro defined).
// Backpressure: in_ready depends only on registered state (low when full or in reset); head holds until popped.
module stream_fifo_buf #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [AW:0]      count,
    output logic             full,
    output logic             empty
);
    localparam logic [AW:0] LP_FULL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;

    logic w_full;
    logic w_empty;
    logic w_bypass;
    logic w_push;
    logic w_pop;

    assign w_full   = (r_count == LP_FULL);
    assign w_empty  = (r_count == '0);
    assign in_ready = !w_full && !rst;

`ifdef STREAM_FIFO_BUF_FALLTHROUGH_EN
    // An empty buffer forwards the producer word directly; it is stored only if the consumer stalls.
    assign w_bypass  = w_empty && in_valid && out_ready && !rst;
    assign out_valid = !w_empty || (in_valid && !rst);
    assign out_data  = w_empty ? in_data : r_mem[r_rd_ptr];
`else
    assign w_bypass  = 1'b0;
    assign out_valid = !w_empty;
    assign out_data  = r_mem[r_rd_ptr];
`endif

    // Flush discards any handshake of its cycle, so it is folded into the push/pop terms.
    assign w_push = in_valid && in_ready && !w_bypass && !flush;
    assign w_pop  = !w_empty && out_ready && !flush;

    assign count = r_count;
    assign full  = w_full;
    assign empty = w_empty;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end
endmodule

// File: tb/tb_stream_fifo_buf.sv
// Self-checking bench for stream_fifo_buf (DEPTH=4, WIDTH=32) against a queue-based reference model.
module tb_stream_fifo_buf;
    localparam int WIDTH = 32;
    localparam int DEPTH = 4;
`ifdef STREAM_FIFO_BUF_FALLTHROUGH_EN
    localparam bit FT = 1'b1;
`else
    localparam bit FT = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             flush;
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic [2:0]       count;
    logic             full;
    logic             empty;

    int total = 0;
    int bad   = 0;
    logic [WIDTH-1:0] q[$];

    stream_fifo_buf #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .count(count), .full(full), .empty(empty)
    );

    always #5 clk = ~clk;

    // Reference model: a bounded FIFO queue of accepted words.
    function automatic logic m_in_ready();
        return !rst && (q.size() < DEPTH);
    endfunction

    function automatic logic m_out_valid();
        return (q.size() > 0) || (FT && in_valid && !rst);
    endfunction

    function automatic logic [WIDTH-1:0] m_out_data();
        return (q.size() > 0) ? q[0] : in_data;
    endfunction

    // Advance one clock edge and move the model forward with the inputs as applied.
    task automatic tick();
        logic bypass, push, pop;
        bypass = FT && (q.size() == 0) && in_valid && out_ready && !rst;
        pop    = (q.size() > 0) && out_ready;
        push   = in_valid && m_in_ready() && !bypass;
        @(posedge clk);
        if (rst || flush) begin
            q.delete();
        end else begin
            if (pop)  void'(q.pop_front());
            if (push) q.push_back(in_data);
        end
        #1;
    endtask

    task automatic idle_inputs();
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        #1;
        total++;
        if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
        tick();
        tick();
        rst = 1'b0;
        #1;
        total++;
        if (count !== 3'd0 || empty !== 1'b1 || full !== 1'b0 || out_valid !== 1'b0) begin
            bad++; $display("FAIL reset_state: count=%0d empty=%b full=%b out_valid=%b want 0/1/0/0", count, empty, full, out_valid);
        end
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_release_in_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_fill();
        idle_inputs();
        for (int i = 0; i < DEPTH; i++) begin
            in_valid = 1'b1; in_data = 32'hA0 + i;
            #1;
            tick();
            total++;
            if (count !== 3'(i + 1)) begin bad++; $display("FAIL fill_count%0d: got %0d want %0d", i, count, i + 1); end
        end
        in_data = 32'hA4;
        #1;
        total++;
        if (full !== 1'b1 || in_ready !== 1'b0) begin bad++; $display("FAIL fill_full: full=%b in_ready=%b want 1/0", full, in_ready); end
        tick();
        total++;
        if (count !== 3'd4 || out_data !== 32'hA0) begin
            bad++; $display("FAIL fill_hold: count=%0d head=%0h want 4/a0", count, out_data);
        end
        in_valid = 1'b0;
    endtask

    task automatic test_drain();
        out_ready = 1'b1; in_valid = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            #1;
            total++;
            if (out_valid !== 1'b1 || out_data !== 32'hA0 + i) begin
                bad++; $display("FAIL drain_word%0d: valid=%b data=%0h want 1/%0h", i, out_valid, out_data, 32'hA0 + i);
            end
            tick();
            total++;
            if (in_ready !== 1'b1) begin bad++; $display("FAIL drain_in_ready%0d: got %b want 1", i, in_ready); end
        end
        total++;
        if (empty !== 1'b1 || count !== 3'd0 || out_valid !== 1'b0) begin
            bad++; $display("FAIL drain_empty: empty=%b count=%0d valid=%b want 1/0/0", empty, count, out_valid);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_stream_wrap();
        logic [WIDTH-1:0] got[$];
        out_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            in_valid = (i < 10); in_data = i;
            #1;
            if (out_valid && out_ready) got.push_back(out_data);
            tick();
            if (i >= 1 && i < 10) begin
                total++;
                if (count !== 3'(FT ? 0 : 1)) begin bad++; $display("FAIL stream_count%0d: got %0d want %0d", i, count, FT ? 0 : 1); end
            end
        end
        total++;
        if (got.size() != 10) begin bad++; $display("FAIL stream_len: got %0d want 10", got.size()); end
        for (int i = 0; i < got.size() && i < 10; i++) begin
            total++;
            if (got[i] !== i) begin bad++; $display("FAIL stream_word%0d: got %0h want %0h", i, got[i], i); end
        end
        in_valid = 1'b0; out_ready = 1'b0;
    endtask

    task automatic test_full_simul();
        idle_inputs();
        for (int i = 0; i < DEPTH; i++) begin
            in_valid = 1'b1; in_data = 32'hB0 + i; #1; tick();
        end
        in_data = 32'hB4; out_ready = 1'b1;
        #1;
        total++;
        if (in_ready !== 1'b0) begin bad++; $display("FAIL fullsim_in_ready: got %b want 0", in_ready); end
        tick();
        total++;
        if (count !== 3'd3 || in_ready !== 1'b1) begin bad++; $display("FAIL fullsim_pop_only: count=%0d in_ready=%b want 3/1", count, in_ready); end
        tick();
        total++;
        if (count !== 3'd3 || out_data !== 32'hB2) begin bad++; $display("FAIL fullsim_push_pop: count=%0d head=%0h want 3/b2", count, out_data); end
        in_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) tick();
        out_ready = 1'b0;
    endtask

    task automatic test_flush_reset();
        idle_inputs();
        for (int i = 0; i < 3; i++) begin in_valid = 1'b1; in_data = 32'hC0 + i; #1; tick(); end
        flush = 1'b1; in_data = 32'hC3;
        #1;
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL flush_in_ready: got %b want 1", in_ready); end
        tick();
        flush = 1'b0; in_valid = 1'b0;
        #1;
        total++;
        if (count !== 3'd0 || empty !== 1'b1 || out_valid !== 1'b0) begin
            bad++; $display("FAIL flush_clear: count=%0d empty=%b valid=%b want 0/1/0", count, empty, out_valid);
        end
        for (int i = 0; i < 3; i++) begin in_valid = 1'b1; in_data = 32'hD0 + i; #1; tick(); end
        rst = 1'b1; in_data = 32'hD3;
        #1;
        total++;
        if (in_ready !== 1'b0) begin bad++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
        tick();
        rst = 1'b0; in_valid = 1'b0;
        #1;
        total++;
        if (count !== 3'd0 || empty !== 1'b1 || out_valid !== 1'b0) begin
            bad++; $display("FAIL rst_clear: count=%0d empty=%b valid=%b want 0/1/0", count, empty, out_valid);
        end
        in_valid = 1'b1; in_data = 32'hE0; #1; tick(); in_valid = 1'b0; out_ready = 1'b1;
        #1;
        total++;
        if (out_valid !== 1'b1 || out_data !== 32'hE0) begin
            bad++; $display("FAIL post_rst_word: valid=%b data=%0h want 1/e0", out_valid, out_data);
        end
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_fallthrough();
        idle_inputs();
        in_valid = 1'b1; in_data = 32'h55; out_ready = 1'b1;
        #1;
        total++;
        if (out_valid !== FT || (FT && out_data !== 32'h55)) begin
            bad++; $display("FAIL ft_same_cycle: valid=%b data=%0h want %b/55", out_valid, out_data, FT);
        end
        tick();
        in_valid = 1'b0;
        #1;
        total++;
        if (count !== 3'(FT ? 0 : 1)) begin bad++; $display("FAIL ft_count: got %0d want %0d", count, FT ? 0 : 1); end
        total++;
        if (out_valid !== !FT || (!FT && out_data !== 32'h55)) begin
            bad++; $display("FAIL ft_next_cycle: valid=%b data=%0h want %b/55", out_valid, out_data, !FT);
        end
        tick();
        out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h66;
        #1;
        tick();
        in_valid = 1'b0; out_ready = 1'b1;
        #1;
        total++;
        if (count !== 3'd1 || out_data !== 32'h66) begin bad++; $display("FAIL ft_stall_store: count=%0d data=%0h want 1/66", count, out_data); end
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_random();
        idle_inputs();
        for (int c = 0; c < 400; c++) begin
            if (!in_valid || in_ready) begin
                in_valid = ($urandom_range(0, 3) != 0);
                in_data  = $urandom;
            end
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 39) == 0);
            rst       = ($urandom_range(0, 99) == 0);
            #1;
            total++;
            if (in_ready !== m_in_ready()) begin bad++; $display("FAIL rnd_in_ready c%0d: got %b want %b", c, in_ready, m_in_ready()); end
            total++;
            if (out_valid !== m_out_valid()) begin bad++; $display("FAIL rnd_out_valid c%0d: got %b want %b", c, out_valid, m_out_valid()); end
            if (m_out_valid()) begin
                total++;
                if (out_data !== m_out_data()) begin bad++; $display("FAIL rnd_out_data c%0d: got %0h want %0h", c, out_data, m_out_data()); end
            end
            total++;
            if (count !== 3'(q.size()) || full !== (q.size() == DEPTH) || empty !== (q.size() == 0)) begin
                bad++; $display("FAIL rnd_occupancy c%0d: count=%0d full=%b empty=%b want %0d", c, count, full, empty, q.size());
            end
            tick();
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_fill();
        test_drain();
        test_stream_wrap();
        test_full_simul();
        test_flush_reset();
        test_fallthrough();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
